// File: rtl/bram_portb_arbiter.sv
// bram_portb_arbiter: shares BRAM port B between four peripheral requesters.
// Round-robin request/grant arbitration, one registered port-B access per
// grant, and read data returned with a one-cycle rvalid pulse.
// Optional macro PORTB_DISPLAY_PRIORITY_EN: requester 0 (display) always wins
// when requesting and its wins leave the round-robin pointer untouched.
module bram_portb_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  output logic [ADDR_W-1:0]        addr_b,
  output logic [DATA_W-1:0]        data_b,
  output logic                     we_b,
  input  logic [DATA_W-1:0]        q_b
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
    ST_READ_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          owner_q, owner_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
  logic [DATA_W-1:0]   data_b_q, data_b_d;
  logic                we_b_q, we_b_d;
  logic                busy_q, busy_d;

  logic                any_req;
  logic                rr_found;
  logic [1:0]          rr_idx;
  logic [1:0]          cand;
  logic [1:0]          win_idx;
  logic                ptr_adv;

  // Round-robin search: first requester at or after the pointer, modulo 4.
  always_comb begin
    any_req  = |req;
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    cand     = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand     = ptr_q + 2'(k);
      rr_idx   = (!rr_found && req[cand]) ? cand : rr_idx;
      rr_found = rr_found | req[cand];
    end
  end

  // Winner selection; display priority overrides the rotation when enabled.
  always_comb begin
`ifdef PORTB_DISPLAY_PRIORITY_EN
    if (req[0]) begin
      win_idx = 2'd0;
      ptr_adv = 1'b0;
    end else begin
      // req[0] is low here, so the rotation naturally skips requester 0.
      win_idx = rr_idx;
      ptr_adv = 1'b1;
    end
`else
    win_idx = rr_idx;
    ptr_adv = 1'b1;
`endif
  end

  // Next-state logic of the access sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (we_b_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_READ_WAIT;
        end
      end
      ST_READ_WAIT: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; every output is a flop.
  always_comb begin
    gnt_d    = {NREQ{1'b0}};
    rvalid_d = {NREQ{1'b0}};
    rdata_d  = rdata_q;
    addr_b_d = addr_b_q;
    data_b_d = data_b_q;
    we_b_d   = 1'b0;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d    = NREQ'(1'b1) << win_idx;
          addr_b_d = req_addr[win_idx*ADDR_W +: ADDR_W];
          data_b_d = req_wdata[win_idx*DATA_W +: DATA_W];
          we_b_d   = req_we[win_idx];
          owner_d  = win_idx;
          if (ptr_adv) begin
            ptr_d = win_idx + 2'd1;
          end else begin
            ptr_d = ptr_q;
          end
        end else begin
          we_b_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        we_b_d = 1'b0;
      end
      ST_READ_WAIT: begin
        rdata_d  = q_b;
        rvalid_d = NREQ'(1'b1) << owner_q;
      end
      default: begin
        we_b_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= 2'd0;
      owner_q  <= 2'd0;
      gnt_q    <= {NREQ{1'b0}};
      rvalid_q <= {NREQ{1'b0}};
      rdata_q  <= {DATA_W{1'b0}};
      addr_b_q <= {ADDR_W{1'b0}};
      data_b_q <= {DATA_W{1'b0}};
      we_b_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      addr_b_q <= addr_b_d;
      data_b_q <= data_b_d;
      we_b_q   <= we_b_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt    = gnt_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign busy   = busy_q;
  assign addr_b = addr_b_q;
  assign data_b = data_b_q;
  // Reset during ACCESS suppresses the BRAM write that would land at the
  // end of that cycle, so an interrupted write never completes.
  assign we_b   = we_b_q & ~reset;

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Self-checking bench for bram_portb_arbiter with a registered BRAM model on port B.
module tb_bram_portb_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [15:0] rdata;
  logic        busy;
  logic [15:0] addr_b;
  logic [15:0] data_b;
  logic        we_b;
  logic [15:0] q_b;

  logic [15:0] mem [0:65535];

  typedef struct {
    int          cyc;
    logic [3:0]  vec;
    logic [15:0] data;
  } exp_t;

  exp_t gq[$];
  exp_t rq[$];
  int   cyc;
  int   n_assert;
  int   n_fail;

  bram_portb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .busy      (busy),
    .addr_b    (addr_b),
    .data_b    (data_b),
    .we_b      (we_b),
    .q_b       (q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered single-port BRAM model: read-first, data valid one cycle after address.
  always @(posedge clk) begin
    if (we_b) begin
      mem[addr_b] <= data_b;
    end
    q_b <= mem[addr_b];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock, sample 1 time unit later and pop scoreboard entries due now.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (gq.size() != 0 && gq[0].cyc == cyc) begin
      e = gq.pop_front();
      chk("gnt", {28'd0, gnt}, {28'd0, e.vec});
    end else begin
      chk("gnt_quiet", {28'd0, gnt}, 32'd0);
    end
    if (rq.size() != 0 && rq[0].cyc == cyc) begin
      e = rq.pop_front();
      chk("rvalid", {28'd0, rvalid}, {28'd0, e.vec});
      chk("rdata", {16'd0, rdata}, {16'd0, e.data});
    end else begin
      chk("rvalid_quiet", {28'd0, rvalid}, 32'd0);
    end
  endtask

  task automatic push_gnt(input int c, input int i);
    exp_t e;
    e.cyc  = c;
    e.vec  = 4'b0001 << i;
    e.data = 16'h0000;
    gq.push_back(e);
  endtask

  task automatic push_rd(input int c, input int i, input logic [15:0] d);
    exp_t e;
    e.cyc  = c;
    e.vec  = 4'b0001 << i;
    e.data = d;
    rq.push_back(e);
  endtask

  task automatic drive(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
    req[i]                = 1'b1;
    req_we[i]             = we;
    req_addr[i*16 +: 16]  = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
    chk({tag, "_rvalid"}, {28'd0, rvalid}, 32'd0);
    chk({tag, "_rdata"}, {16'd0, rdata}, 32'd0);
    chk({tag, "_addr_b"}, {16'd0, addr_b}, 32'd0);
    chk({tag, "_data_b"}, {16'd0, data_b}, 32'd0);
    chk({tag, "_we_b"}, {31'd0, we_b}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    check_reset_values("rst");
    reset = 1'b0;
  endtask

  task automatic do_write(input int i, input logic [15:0] a, input logic [15:0] d);
    push_gnt(cyc + 1, i);
    drive(i, 1'b1, a, d);
    tick();
    chk("wr_we_b", {31'd0, we_b}, 32'd1);
    chk("wr_addr_b", {16'd0, addr_b}, {16'd0, a});
    chk("wr_data_b", {16'd0, data_b}, {16'd0, d});
    chk("wr_busy", {31'd0, busy}, 32'd1);
    req[i] = 1'b0;
    tick();
    chk("wr_we_b_clr", {31'd0, we_b}, 32'd0);
    chk("wr_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_read(input int i, input logic [15:0] a, input logic [15:0] d);
    push_gnt(cyc + 1, i);
    push_rd(cyc + 3, i, d);
    drive(i, 1'b0, a, 16'h0000);
    tick();
    chk("rd_addr_b", {16'd0, addr_b}, {16'd0, a});
    chk("rd_we_b", {31'd0, we_b}, 32'd0);
    req[i] = 1'b0;
    tick();
    chk("rd_wait_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("rd_done_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    cyc       = 0;
    reset     = 1'b1;
    req       = 4'b0000;
    req_we    = 4'b0000;
    req_addr  = 64'd0;
    req_wdata = 64'd0;

    // Reset state
    tick();
    do_reset();

    // Single write from requester 2, then a read back by requester 1
    do_write(2, 16'h0040, 16'hBEEF);
    do_read(1, 16'h0040, 16'hBEEF);

    // Preload two words, then back-to-back reads from requester 3 with req held
    do_write(3, 16'h0010, 16'h1111);
    do_write(3, 16'h0011, 16'h2222);
    begin
      int c0;
      c0 = cyc;
      push_gnt(c0 + 1, 3);
      push_rd(c0 + 3, 3, 16'h1111);
      push_gnt(c0 + 4, 3);
      push_rd(c0 + 6, 3, 16'h2222);
      drive(3, 1'b0, 16'h0010, 16'h0000);
      tick();
      req_addr[48 +: 16] = 16'h0011;
      tick();
      tick();
      tick();
      req[3] = 1'b0;
      tick();
      tick();
      tick();
      chk("rdata_hold", {16'd0, rdata}, 32'h0000_2222);
    end

    // Reset asserted in READ_WAIT: no rvalid, everything back to reset values
    push_gnt(cyc + 1, 0);
    drive(0, 1'b0, 16'h0040, 16'h0000);
    tick();
    req[0] = 1'b0;
    tick();
    chk("rw_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    check_reset_values("rw_rst");
    reset = 1'b0;
    tick();
    chk("rw_after_rvalid", {28'd0, rvalid}, 32'd0);

    // Reset asserted in ACCESS of a write: write must not land
    push_gnt(cyc + 1, 1);
    drive(1, 1'b1, 16'h0040, 16'h5555);
    tick();
    req[1] = 1'b0;
    reset  = 1'b1;
    #1;
    chk("abort_we_b", {31'd0, we_b}, 32'd0);
    tick();
    reset = 1'b0;
    do_read(1, 16'h0040, 16'hBEEF);

    // All four requesters writing continuously: 0,1,2,3,0,1 every 2 cycles
    do_reset();
    begin
      int c0;
      c0 = cyc;
      for (int k = 0; k < 6; k++) begin
        push_gnt(c0 + 1 + 2 * k, k % 4);
      end
      for (int i = 0; i < 4; i++) begin
        drive(i, 1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
      end
      for (int k = 1; k <= 12; k++) begin
        tick();
        chk("rr_busy", {31'd0, busy}, {31'd0, 1'(k % 2)});
      end
      req = 4'b0000;
      tick();
      chk("rr_end_idle", {31'd0, busy}, 32'd0);
    end

    // req=1111 held, then req[0] dropped
    do_reset();
    begin
      int c0;
      c0 = cyc;
      for (int k = 0; k < 4; k++) begin
`ifdef PORTB_DISPLAY_PRIORITY_EN
        push_gnt(c0 + 1 + 2 * k, 0);
`else
        push_gnt(c0 + 1 + 2 * k, k);
`endif
      end
      push_gnt(c0 + 9, 1);
      push_gnt(c0 + 11, 2);
      push_gnt(c0 + 13, 3);
      push_gnt(c0 + 15, 1);
      for (int i = 0; i < 4; i++) begin
        drive(i, 1'b1, 16'h0200 + 16'(i), 16'hC000 + 16'(i));
      end
      for (int k = 1; k <= 16; k++) begin
        tick();
        if (k == 7) begin
          req[0] = 1'b0;
        end
      end
      req = 4'b0000;
      tick();
      tick();
    end

    // Every scheduled grant/rvalid must have been consumed
    chk("sb_empty", gq.size() + rq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_portb_arbiter.md
# bram_portb_arbiter

Shares the data BRAM's second port (port B, reserved for peripherals) between four peripheral requesters, such as the Pong display scanner, paddle-input writer, score logic and debug. Each requester uses a request/grant handshake. The block registers the winner's command, drives one port-B access, and returns read data with a one-cycle valid pulse. It sits between the peripheral blocks and the `bram` instance, beside the CPU, which keeps exclusive use of port A.

## Interface
- `NREQ`, 4: number of requesters. Fixed at 4; the arbitration logic is written for 4.
- `ADDR_W`, 16: port-B address width.
- `DATA_W`, 16: port-B data width.
- `clk`  in  1: single clock, shared with the CPU and BRAM.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  4: request per requester. Must be held until `gnt`.
- `req_we`  in  4: per-requester write flag. 1 = write, 0 = read.
- `req_addr`  in  4*ADDR_W: flat address bus. Requester i occupies bits [i*16 +: 16].
- `req_wdata`  in  4*DATA_W: flat write-data bus, same packing as `req_addr`.
- `gnt`  out  4: one-hot, one-cycle grant pulse.
- `rvalid`  out  4: one-hot, one-cycle read-data-valid pulse.
- `rdata`  out  DATA_W: read data, shared by all requesters. Qualified by `rvalid`.
- `busy`  out  1: high whenever the state is not IDLE.
- `addr_b`  out  ADDR_W: BRAM port-B address.
- `data_b`  out  DATA_W: BRAM port-B write data.
- `we_b`  out  1: BRAM port-B write enable.
- `q_b`  in  DATA_W: BRAM port-B read data. Registered in the BRAM, valid 1 cycle after the address.

## Operation
- States: IDLE, ACCESS, READ_WAIT.
- IDLE:
  - If any `req` bit is high, choose a winner and register its `req_addr`, `req_wdata` and `req_we` into `addr_b`, `data_b` and `we_b`.
  - Set `gnt[winner]` and go to ACCESS.
  - If no `req` bit is high, hold `we_b`=0.
- ACCESS: port B is driven for exactly this cycle with `gnt[winner]`=1.
  - Write: next state IDLE; `we_b` clears.
  - Read: next state READ_WAIT.
- READ_WAIT:
  - Capture `q_b` into `rdata` and set `rvalid[winner]` for the next cycle.
  - Next state IDLE.
  - `rdata` holds its value until the next read completes.
- Round-robin:
  - The pointer names the highest-priority requester. Search order is pointer, pointer+1, … modulo 4.
  - After a grant, pointer = winner+1 (wraps 3→0).
  - Reset value of the pointer is 0.
- Requests are not sampled while in ACCESS or READ_WAIT.
- A requester that keeps `req` high in the cycle after `gnt` issues a new, independent access.
- The `req_addr`/`req_wdata` of non-winners are ignored.
- Reset mid-operation:
  - Any in-flight write completes only if reset was low during ACCESS.
  - A pending read response is discarded; no `rvalid` is issued.
  - State returns to IDLE.

## Timing
- Reset values: `gnt`=0, `rvalid`=0, `rdata`=0, `addr_b`=0, `data_b`=0, `we_b`=0, `busy`=0, state IDLE, pointer 0.
- Read, with `req` high in cycle 0 (IDLE):
  - Cycle 1: ACCESS, `gnt` high.
  - Cycle 2: READ_WAIT, `q_b` valid.
  - Cycle 3: `rvalid` high, back in IDLE.
- Write: `gnt` and `we_b` are high in cycle 1; IDLE in cycle 2.
- Arbitration in cycle 3 of a read (IDLE) overlaps the `rvalid` pulse.
- Peak throughput: one write per 2 cycles, one read per 3 cycles.
- All outputs are registered; there are no combinational paths from `req` to `gnt`.

## Configuration
- `PORTB_DISPLAY_PRIORITY_EN` defined:
  - Requester 0 (display) wins whenever `req[0]`=1, regardless of the pointer.
  - A requester-0 win does not move the pointer.
  - Requesters 1–3 round-robin among themselves when `req[0]`=0.
- Not defined: pure 4-way round-robin as described under Operation.

## Test plan
- Reset, then a single write from requester 2 (addr 0x0040, data 0xBEEF):
  - `gnt`=4'b0100, `we_b`=1, `addr_b`=0x0040 in cycle 1; `we_b`=0 in cycle 2.
  - A following read from requester 1 at 0x0040 gives `rvalid`=4'b0010 and `rdata`=0xBEEF, 3 cycles after its `req`.
- All four requesters hold `req` continuously, all writing:
  - Grant order is 0,1,2,3,0,… with one `gnt` every 2 cycles.
  - `busy` alternates accordingly.
- Back-to-back reads from requester 3 (addr 0x0010, then 0x0011, memory preloaded 0x1111/0x2222):
  - `rvalid[3]` in cycles 3 and 6.
  - `rdata` = 0x1111 then 0x2222.
- Read granted, then `reset` asserted in READ_WAIT:
  - No `rvalid` pulse.
  - All outputs return to reset values on the next cycle.
- With `PORTB_DISPLAY_PRIORITY_EN` defined, `req`=4'b1111 held:
  - Every grant goes to requester 0.
  - Dropping `req[0]` yields grants 1,2,3,1 in that order.
  - Without the macro, the same stimulus yields 0,1,2,3.
